// File: rtl/video_pkg.sv
// Shared video timing constants (640x480@60) and coordinate width.
// The optional colour-bar helper is used when VIDEO_TIMING_TEST_PATTERN_EN is defined.
package video_pkg;

    localparam int COORD_W = 11;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // Raw (active-high) per-pixel control bits carried down the alignment pipe.
    typedef struct packed {
        logic blank;
        logic hsync;
        logic vsync;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{blank: 1'b1, hsync: 1'b0, vsync: 1'b0};

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        return {{8{idx[2]}}, {8{idx[1]}}, {8{idx[0]}}};
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift pipeline with asynchronous clear to a programmable idle value.
// o_pre is the value about to enter the last stage (the input itself when DEPTH=1).
module sync_delay_line #(
    parameter int                DEPTH   = 2,
    parameter int                WIDTH   = 3,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_pre,
    output logic [WIDTH-1:0] o_q
);

    logic [DEPTH:1][WIDTH-1:0] r_stage;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage <= {DEPTH{RST_VAL}};
        end else begin
            r_stage[1] <= i_d;
            for (int i = 2; i <= DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    if (DEPTH == 1) begin : g_pre_direct
        assign o_pre = i_d;
    end else begin : g_pre_tap
        assign o_pre = r_stage[DEPTH-1];
    end

    assign o_q = r_stage[DEPTH];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel fetch requests plus latency-aligned sync/blank/colour.
// Define VIDEO_TIMING_TEST_PATTERN_EN to add the testPattern colour-bar input.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE        = VGA_H_ACTIVE,
    parameter int H_FP            = VGA_H_FP,
    parameter int H_SYNC          = VGA_H_SYNC,
    parameter int H_BP            = VGA_H_BP,
    parameter int V_ACTIVE        = VGA_V_ACTIVE,
    parameter int V_FP            = VGA_V_FP,
    parameter int V_SYNC          = VGA_V_SYNC,
    parameter int V_BP            = VGA_V_BP,
    parameter int FETCH_LAT       = 2,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic               clkRGB,
    input  logic               reset,
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    input  logic               testPattern,
`endif
    output logic               pixReq,
    output logic [COORD_W-1:0] pixX,
    output logic [COORD_W-1:0] pixY,
    input  logic [23:0]        pixData,
    output logic [7:0]         rRGB,
    output logic [7:0]         gRGB,
    output logic [7:0]         bRGB,
    output logic               hs,
    output logic               vs,
    output logic               blk,
    output logic               frameStart,
    output logic               lineStart
);

    localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [COORD_W-1:0] r_hCnt, r_vCnt;
    logic               w_visible, w_atLineStart;
    sync_t              w_raw, w_pre, w_dly;
    logic [23:0]        w_src, r_rgb;

    always_ff @(posedge clkRGB or posedge reset) begin
        if (reset) begin
            r_hCnt <= '0;
            r_vCnt <= '0;
        end else if (r_hCnt == H_LAST) begin
            r_hCnt <= '0;
            r_vCnt <= (r_vCnt == V_LAST) ? '0 : r_vCnt + ONE;
        end else begin
            r_hCnt <= r_hCnt + ONE;
        end
    end

    // Counters already sit at (0,0) during reset; gating keeps the undelayed outputs quiet.
    assign w_visible     = !reset && (r_hCnt < H_VIS) && (r_vCnt < V_VIS);
    assign w_atLineStart = !reset && (r_hCnt == '0);

    assign pixReq     = w_visible;
    assign pixX       = w_visible ? r_hCnt : '0;
    assign pixY       = w_visible ? r_vCnt : '0;
    assign lineStart  = w_atLineStart;
    assign frameStart = w_atLineStart && (r_vCnt == '0);

    assign w_raw.blank = !((r_hCnt < H_VIS) && (r_vCnt < V_VIS));
    assign w_raw.hsync = (r_hCnt >= HS_START) && (r_hCnt < HS_END);
    assign w_raw.vsync = (r_vCnt >= VS_START) && (r_vCnt < VS_END);

    sync_delay_line #(
        .DEPTH   (FETCH_LAT),
        .WIDTH   (3),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_dly (
        .clk   (clkRGB),
        .rst   (reset),
        .i_d   (w_raw),
        .o_pre (w_pre),
        .o_q   (w_dly)
    );

`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    logic [2:0] w_barIdx;

    // Bar index travels with the request so pattern colour has the same latency as pixData.
    if (FETCH_LAT == 1) begin : g_bar_direct
        assign w_barIdx = pixX[9:7];
    end else begin : g_bar_pipe
        logic [FETCH_LAT-2:0][2:0] r_bar;
        always_ff @(posedge clkRGB or posedge reset) begin
            if (reset) begin
                r_bar <= '0;
            end else begin
                r_bar[0] <= pixX[9:7];
                for (int i = 1; i < FETCH_LAT - 1; i++) begin
                    r_bar[i] <= r_bar[i-1];
                end
            end
        end
        assign w_barIdx = r_bar[FETCH_LAT-2];
    end

    assign w_src = testPattern ? bar_colour(w_barIdx) : pixData;
`else
    assign w_src = pixData;
`endif

    // Colour is loaded on the same edge that moves w_pre into the final sync stage.
    always_ff @(posedge clkRGB or posedge reset) begin
        if (reset) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= w_pre.blank ? 24'h0 : w_src;
        end
    end

    assign {rRGB, gRGB, bRGB} = r_rgb;
    assign blk = w_dly.blank;
    assign hs  = SYNC_ACTIVE_LOW ? ~w_dly.hsync : w_dly.hsync;
    assign vs  = SYNC_ACTIVE_LOW ? ~w_dly.vsync : w_dly.vsync;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default horizontal timing, shortened vertical timing (12 lines) so full
// frames stay short; checks reset, line/frame periods, sync placement, colour gating.
module tb_video_timing_gen;

    localparam int V_ACT = 6, V_FPO = 2, V_SYN = 2, V_BPO = 2;
    localparam int HTOT  = 800;
    localparam int VTOT  = V_ACT + V_FPO + V_SYN + V_BPO;
    localparam logic [23:0] COLOUR = 24'hA5C33C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] pixData = COLOUR;
    logic        pixReq, hs, vs, blk, frameStart, lineStart;
    logic [10:0] pixX, pixY;
    logic [7:0]  rRGB, gRGB, bRGB;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .V_ACTIVE (V_ACT),
        .V_FP     (V_FPO),
        .V_SYNC   (V_SYN),
        .V_BP     (V_BPO)
    ) dut (
        .clkRGB     (clk),
        .reset      (reset),
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
        .testPattern(1'b0),
`endif
        .pixReq     (pixReq),
        .pixX       (pixX),
        .pixY       (pixY),
        .pixData    (pixData),
        .rRGB       (rRGB),
        .gRGB       (gRGB),
        .bRGB       (bRGB),
        .hs         (hs),
        .vs         (vs),
        .blk        (blk),
        .frameStart (frameStart),
        .lineStart  (lineStart)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_line_start();
        int n = 0;
        do begin tick(); n++; end while (!lineStart && n < 2000);
        checks++;
        if (!lineStart) begin
            failures++;
            $display("FAIL line_start_timeout: lineStart=%0b after %0d cycles, want 1", lineStart, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (pixReq !== 1'b0 || pixX !== 11'd0 || pixY !== 11'd0) begin
            failures++;
            $display("FAIL reset_req: pixReq=%0b x=%0d y=%0d, want 0 0 0", pixReq, pixX, pixY);
        end
        checks++;
        if ({rRGB, gRGB, bRGB} !== 24'h0 || blk !== 1'b1) begin
            failures++;
            $display("FAIL reset_video: rgb=%h blk=%0b, want 000000 1", {rRGB, gRGB, bRGB}, blk);
        end
        checks++;
        if (hs !== 1'b1 || vs !== 1'b1 || frameStart !== 1'b0 || lineStart !== 1'b0) begin
            failures++;
            $display("FAIL reset_sync: hs=%0b vs=%0b fs=%0b ls=%0b, want 1 1 0 0", hs, vs, frameStart, lineStart);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (frameStart !== 1'b1 || pixReq !== 1'b1 || pixX !== 11'd0 || pixY !== 11'd0) begin
            failures++;
            $display("FAIL release_first: fs=%0b req=%0b x=%0d y=%0d, want 1 1 0 0", frameStart, pixReq, pixX, pixY);
        end
        tick();
        checks++;
        if (blk !== 1'b1) begin
            failures++;
            $display("FAIL release_blk1: blk=%0b at cycle 1, want 1", blk);
        end
        tick();
        checks++;
        if (blk !== 1'b0 || {rRGB, gRGB, bRGB} !== COLOUR) begin
            failures++;
            $display("FAIL release_blk2: blk=%0b rgb=%h at cycle 2, want 0 %h", blk, {rRGB, gRGB, bRGB}, COLOUR);
        end
    endtask

    task automatic test_line_count();
        int len = 0;
        int req;
        wait_line_start();
        req = int'(pixReq);
        do begin
            tick();
            len++;
            if (!lineStart) req += int'(pixReq);
        end while (!lineStart && len < 2000);
        checks++;
        if (len != HTOT) begin
            failures++;
            $display("FAIL line_period: got %0d cycles, want %0d", len, HTOT);
        end
        checks++;
        if (req != 640) begin
            failures++;
            $display("FAIL line_pixreq: got %0d, want 640", req);
        end
    endtask

    task automatic test_hsync();
        int first = -1, last = -1, cnt = 0;
        wait_line_start();
        for (int c = 0; c < HTOT; c++) begin
            if (hs === 1'b0) begin
                if (first < 0) first = c;
                last = c;
                cnt++;
            end
            tick();
        end
        checks++;
        if (first != 658 || last != 753) begin
            failures++;
            $display("FAIL hs_window: low %0d..%0d, want 658..753", first, last);
        end
        checks++;
        if (cnt != 96) begin
            failures++;
            $display("FAIL hs_width: got %0d, want 96", cnt);
        end
    endtask

    task automatic test_colour();
        int bad = 0, vis = 0;
        wait_line_start();
        for (int c = 0; c < HTOT; c++) begin
            if (blk === 1'b0) begin
                vis++;
                if ({rRGB, gRGB, bRGB} !== COLOUR) bad++;
            end else if ({rRGB, gRGB, bRGB} !== 24'h0) begin
                bad++;
            end
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL colour_gate: %0d bad cycles, want 0", bad);
        end
        checks++;
        if (vis != 640) begin
            failures++;
            $display("FAIL colour_visible: blk low %0d cycles, want 640", vis);
        end
    endtask

    task automatic test_frame();
        int n = 0, i = 0, req = 0, vsFirst = -1, vsCnt = 0;
        do begin tick(); n++; end while (!frameStart && n < 20000);
        checks++;
        if (!frameStart) begin
            failures++;
            $display("FAIL frame_start_timeout: frameStart=%0b, want 1", frameStart);
        end
        do begin
            req += int'(pixReq);
            if (vs === 1'b0) begin
                if (vsFirst < 0) vsFirst = i;
                vsCnt++;
            end
            tick();
            i++;
        end while (!frameStart && i < 20000);
        checks++;
        if (i != HTOT * VTOT) begin
            failures++;
            $display("FAIL frame_period: got %0d, want %0d", i, HTOT * VTOT);
        end
        checks++;
        if (req != 640 * V_ACT) begin
            failures++;
            $display("FAIL frame_pixreq: got %0d, want %0d", req, 640 * V_ACT);
        end
        checks++;
        if (vsFirst != (V_ACT + V_FPO) * HTOT + 2 || vsCnt != V_SYN * HTOT) begin
            failures++;
            $display("FAIL vs_window: start %0d len %0d, want %0d %0d",
                     vsFirst, vsCnt, (V_ACT + V_FPO) * HTOT + 2, V_SYN * HTOT);
        end
    endtask

    // Entered at a frameStart sample, i.e. counters at (0,0).
    task automatic test_reset_mid();
        repeat (3 * HTOT + 300) tick();
        checks++;
        if (pixReq !== 1'b1 || pixX !== 11'd300 || pixY !== 11'd3 || blk !== 1'b0 || {rRGB, gRGB, bRGB} !== COLOUR) begin
            failures++;
            $display("FAIL mid_before: req=%0b x=%0d y=%0d blk=%0b rgb=%h, want 1 300 3 0 %h",
                     pixReq, pixX, pixY, blk, {rRGB, gRGB, bRGB}, COLOUR);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (pixReq !== 1'b0 || pixX !== 11'd0 || blk !== 1'b1 || {rRGB, gRGB, bRGB} !== 24'h0 ||
            hs !== 1'b1 || vs !== 1'b1 || lineStart !== 1'b0) begin
            failures++;
            $display("FAIL mid_async: req=%0b x=%0d blk=%0b rgb=%h hs=%0b vs=%0b ls=%0b, want 0 0 1 0 1 1 0",
                     pixReq, pixX, blk, {rRGB, gRGB, bRGB}, hs, vs, lineStart);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (frameStart !== 1'b1 || pixReq !== 1'b1 || pixX !== 11'd0 || pixY !== 11'd0) begin
            failures++;
            $display("FAIL mid_restart: fs=%0b req=%0b x=%0d y=%0d, want 1 1 0 0", frameStart, pixReq, pixX, pixY);
        end
        tick();
        checks++;
        if (blk !== 1'b1 || {rRGB, gRGB, bRGB} !== 24'h0) begin
            failures++;
            $display("FAIL mid_stale: blk=%0b rgb=%h at cycle 1, want 1 000000", blk, {rRGB, gRGB, bRGB});
        end
        tick();
        checks++;
        if (blk !== 1'b0 || {rRGB, gRGB, bRGB} !== COLOUR || pixX !== 11'd2) begin
            failures++;
            $display("FAIL mid_resume: blk=%0b rgb=%h x=%0d, want 0 %h 2", blk, {rRGB, gRGB, bRGB}, pixX, COLOUR);
        end
    endtask

    initial begin
        test_reset();
        test_line_count();
        test_hsync();
        test_colour();
        test_frame();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
